// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single port of the node memory.
// Round-robin grant with burst lock, burst cap and registered read return.
//
// Ports:
//   clock, nrst               clock, async active-low reset
//   req*/lock*/addr*/wr*/wdata*  requester 0 (routing) and 1 (host)
//   gnt*, rvalid*, rdata*     registered grant and read return
//   mem_addr/mem_wr_en/mem_wdata/mem_rdata  memory port
//   err                       pulse after a rejected access
// Build option: define MEM_ARB_ADDR_CHECK_EN to reject word addresses
// above ADDR_LIMIT (write suppressed, read returns zero, err pulses).
module mem_port_arbiter #(
    parameter int unsigned MAX_BURST  = 16,
    parameter logic [15:0] ADDR_LIMIT = 16'h07FE
) (
    input  logic        clock,
    input  logic        nrst,
    input  logic        req0,
    input  logic        req1,
    input  logic        lock0,
    input  logic        lock1,
    input  logic [15:0] addr0,
    input  logic [15:0] addr1,
    input  logic        wr0,
    input  logic        wr1,
    input  logic [15:0] wdata0,
    input  logic [15:0] wdata1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic [15:0] rdata0,
    output logic [15:0] rdata1,
    output logic [15:0] mem_addr,
    output logic        mem_wr_en,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        err
);

`ifdef MEM_ARB_ADDR_CHECK_EN
    localparam logic CHECK_EN = 1'b1;
`else
    localparam logic CHECK_EN = 1'b0;
`endif

    localparam logic [7:0] BURST_LIM = 8'(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t      state_q;
    logic        ptr_q;
    logic [7:0]  cnt_q;
    logic        gnt0_q;
    logic        gnt1_q;
    logic        rvalid0_q;
    logic        rvalid1_q;
    logic        err_q;
    logic [15:0] rdata0_q;
    logic [15:0] rdata1_q;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;

    logic        own0;
    logic        own1;
    logic        owning;
    logic        cur_req;
    logic        cur_lock;
    logic        cur_wr;
    logic [15:0] cur_addr;
    logic [15:0] cur_wdata;
    logic        acc0;
    logic        acc1;
    logic        acc;
    logic        addr_ok;
    logic [7:0]  cnt_d;
    logic        burst_end;
    logic        release_own;
    logic [15:0] rd_data;

    assign own0      = (state_q == OWN0);
    assign own1      = (state_q == OWN1);
    assign owning    = own0 | own1;

    assign cur_req   = own1 ? req1   : req0;
    assign cur_lock  = own1 ? lock1  : lock0;
    assign cur_wr    = own1 ? wr1    : wr0;
    assign cur_addr  = own1 ? addr1  : addr0;
    assign cur_wdata = own1 ? wdata1 : wdata0;

    assign acc0      = own0 & req0;
    assign acc1      = own1 & req1;
    assign acc       = acc0 | acc1;

    // Constant-folds to 1 when the address check is not built in.
    assign addr_ok   = ~CHECK_EN | (cur_addr <= ADDR_LIMIT);

    assign cnt_d     = cnt_q + 8'd1;
    assign burst_end = (cnt_d == BURST_LIM);

    // Owner dropping req ends the grant without an access.
    assign release_own = owning &
                         (~cur_req | ~cur_lock | burst_end);

    assign rd_data   = addr_ok ? mem_rdata : 16'h0000;

    // Outside a grant the port holds its last address and data.
    assign mem_addr  = owning ? cur_addr  : addr_q;
    assign mem_wdata = owning ? cur_wdata : wdata_q;
    assign mem_wr_en = acc & cur_wr & addr_ok;

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign rvalid0   = rvalid0_q;
    assign rvalid1   = rvalid1_q;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;
    assign err       = err_q;

    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            state_q   <= IDLE;
            ptr_q     <= 1'b0;
            cnt_q     <= 8'd0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            err_q     <= 1'b0;
            rdata0_q  <= 16'h0000;
            rdata1_q  <= 16'h0000;
            addr_q    <= 16'h0000;
            wdata_q   <= 16'h0000;
        end else begin
            rvalid0_q <= acc0 & ~wr0;
            rvalid1_q <= acc1 & ~wr1;
            err_q     <= acc & ~addr_ok;
            if (acc0 & ~wr0) begin
                rdata0_q <= rd_data;
            end
            if (acc1 & ~wr1) begin
                rdata1_q <= rd_data;
            end
            if (owning) begin
                addr_q  <= cur_addr;
                wdata_q <= cur_wdata;
            end
            unique case (state_q)
                IDLE: begin
                    // ptr_q = 1 favours requester 1 on a tie.
                    if (req0 & (~req1 | ~ptr_q)) begin
                        state_q <= OWN0;
                        gnt0_q  <= 1'b1;
                    end else if (req1) begin
                        state_q <= OWN1;
                        gnt1_q  <= 1'b1;
                    end
                end
                OWN0, OWN1: begin
                    if (release_own) begin
                        state_q <= IDLE;
                        gnt0_q  <= 1'b0;
                        gnt1_q  <= 1'b0;
                        ptr_q   <= own0;
                        cnt_q   <= 8'd0;
                    end else if (acc) begin
                        cnt_q <= cnt_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt0_q  <= 1'b0;
                    gnt1_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule
